// File: rtl/hawk_axi_cl_master.sv
// Cacheline-to-AXI4 master: turns single 512-bit read/write requests into 2-beat 256-bit
// INCR bursts, one transaction outstanding, and returns the result on a valid/ready port.
module hawk_axi_cl_master #(
    parameter int unsigned ID_W        = 6,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [63:0]      req_addr,
    input  logic [511:0]     req_wdata,
    input  logic [63:0]      req_wmask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_wr,
    output logic [511:0]     rsp_rdata,
    output logic             rsp_err,
    output logic             axi_awvalid,
    input  logic             axi_awready,
    output logic [ID_W-1:0]  axi_awid,
    output logic [63:0]      axi_awaddr,
    output logic [7:0]       axi_awlen,
    output logic [2:0]       axi_awsize,
    output logic [1:0]       axi_awburst,
    output logic             axi_wvalid,
    input  logic             axi_wready,
    output logic [255:0]     axi_wdata,
    output logic [31:0]      axi_wstrb,
    output logic             axi_wlast,
    input  logic             axi_bvalid,
    output logic             axi_bready,
    input  logic [ID_W-1:0]  axi_bid,
    input  logic [1:0]       axi_bresp,
    output logic             axi_arvalid,
    input  logic             axi_arready,
    output logic [ID_W-1:0]  axi_arid,
    output logic [63:0]      axi_araddr,
    output logic [7:0]       axi_arlen,
    output logic [2:0]       axi_arsize,
    output logic [1:0]       axi_arburst,
    input  logic             axi_rvalid,
    output logic             axi_rready,
    input  logic [ID_W-1:0]  axi_rid,
    input  logic [255:0]     axi_rdata,
    input  logic [1:0]       axi_rresp,
    input  logic             axi_rlast,
    output logic             timeout_err,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        StIdle, StWrAw, StWrW0, StWrW1, StWrB, StRdAr, StRdR, StResp
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     addr_q, addr_d;
    logic [511:0]    wdata_q, wdata_d;
    logic [63:0]     wmask_q, wmask_d;
    logic [255:0]    wbeat_q, wbeat_d;
    logic [31:0]     wstrb_q, wstrb_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            req_ready_q, req_ready_d;
    logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
    logic            bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d, rsp_err_q, rsp_err_d;
    logic [511:0]    rdata_q, rdata_d;
    logic            beat_q, beat_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            timeout_q, timeout_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic            busy;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        wbeat_d     = wbeat_q;
        wstrb_d     = wstrb_q;
        id_d        = id_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        wlast_d     = wlast_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_err_d   = rsp_err_q;
        rdata_d     = rdata_q;
        beat_d      = beat_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        busy        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d    = {req_addr[63:6], 6'b0};
                    wdata_d   = req_wdata;
                    wmask_d   = req_wmask;
                    rsp_wr_d  = req_wr;
                    rsp_err_d = 1'b0;
                    rdata_d   = '0;
                    if (!req_wr) begin
                        arvalid_d = 1'b1;
                        state_d   = StRdAr;
                    end else if (req_wmask == '0) begin
                        // nothing to write: complete locally without touching the bus
                        state_d = StResp;
                    end else begin
                        awvalid_d = 1'b1;
                        state_d   = StWrAw;
                    end
                end
            end
            StWrAw: begin
                busy = 1'b1;
                if (axi_awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wbeat_d   = wdata_q[255:0];
                    wstrb_d   = wmask_q[31:0];
                    wlast_d   = 1'b0;
                    state_d   = StWrW0;
                end
            end
            StWrW0: begin
                busy = 1'b1;
                if (axi_wready) begin
                    wbeat_d = wdata_q[511:256];
                    wstrb_d = wmask_q[63:32];
                    wlast_d = 1'b1;
                    state_d = StWrW1;
                end
            end
            StWrW1: begin
                busy = 1'b1;
                if (axi_wready) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                    bready_d = 1'b1;
                    state_d  = StWrB;
                end
            end
            StWrB: begin
                busy = 1'b1;
                if (axi_bvalid) begin
                    bready_d  = 1'b0;
                    rsp_err_d = (axi_bresp != 2'b00) || (axi_bid != id_q);
                    id_d      = id_q + ID_W'(1);
                    wr_cnt_d  = (&wr_cnt_q) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
                    state_d   = StResp;
                end
            end
            StRdAr: begin
                busy = 1'b1;
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    beat_d    = 1'b0;
                    state_d   = StRdR;
                end
            end
            StRdR: begin
                busy = 1'b1;
                if (axi_rvalid) begin
                    if (beat_q) rdata_d[511:256] = axi_rdata;
                    else        rdata_d[255:0]   = axi_rdata;
                    // rlast must be set on exactly the second beat
                    rsp_err_d = rsp_err_q || (axi_rresp != 2'b00) || (axi_rid != id_q) ||
                                (axi_rlast != beat_q);
                    if (beat_q) begin
                        rready_d = 1'b0;
                        id_d     = id_q + ID_W'(1);
                        rd_cnt_d = (&rd_cnt_q) ? rd_cnt_q : rd_cnt_q + CNT_W'(1);
                        state_d  = StResp;
                    end else begin
                        beat_d = 1'b1;
                    end
                end
            end
            StResp: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        req_ready_d = (state_d == StIdle);

        if (!busy || (state_d != state_q)) begin
            tmo_d = '0;
        end else if (tmo_q != TmoW'(TIMEOUT_CYC)) begin
            tmo_d = tmo_q + TmoW'(1);
        end else begin
            tmo_d = tmo_q;
        end
        timeout_d = timeout_q || (busy && (tmo_q == TmoW'(TIMEOUT_CYC)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            id_q        <= '0;
            beat_q      <= 1'b0;
            tmo_q       <= '0;
            timeout_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            id_q        <= id_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            timeout_q   <= timeout_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    // Payload registers need no reset; they are only observed alongside a valid.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
        wbeat_q <= wbeat_d;
        wstrb_q <= wstrb_d;
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_wr      = rsp_wr_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = rsp_err_q;
    assign axi_awvalid = awvalid_q;
    assign axi_awid    = id_q;
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = 8'd1;
    assign axi_awsize  = 3'd5;
    assign axi_awburst = 2'b01;
    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = wbeat_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wlast   = wlast_q;
    assign axi_bready  = bready_q;
    assign axi_arvalid = arvalid_q;
    assign axi_arid    = id_q;
    assign axi_araddr  = addr_q;
    assign axi_arlen   = 8'd1;
    assign axi_arsize  = 3'd5;
    assign axi_arburst = 2'b01;
    assign axi_rready  = rready_q;
    assign timeout_err = timeout_q;
    assign wr_cnt      = wr_cnt_q;
    assign rd_cnt      = rd_cnt_q;

endmodule

// File: tb/tb_hawk_axi_cl_master.sv
// Directed bench for hawk_axi_cl_master: reactive AXI slave with memory, response scoreboard.
module tb_hawk_axi_cl_master;

    localparam int ID_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_wr;
    logic [63:0]      req_addr;
    logic [511:0]     req_wdata;
    logic [63:0]      req_wmask;
    logic             rsp_valid, rsp_ready, rsp_wr, rsp_err;
    logic [511:0]     rsp_rdata;
    logic             awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [ID_W-1:0]  awid, bid, arid, rid;
    logic [63:0]      awaddr, araddr;
    logic [7:0]       awlen, arlen;
    logic [2:0]       awsize, arsize;
    logic [1:0]       awburst, arburst, bresp, rresp;
    logic [255:0]     wdata, rdata;
    logic [31:0]      wstrb;
    logic             arvalid, arready, rvalid, rready, rlast;
    logic             timeout_err;
    logic [31:0]      wr_cnt, rd_cnt;

    hawk_axi_cl_master #(.ID_W(ID_W), .TIMEOUT_CYC(1024), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .axi_awvalid(awvalid), .axi_awready(awready), .axi_awid(awid), .axi_awaddr(awaddr),
        .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst),
        .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_wlast(wlast), .axi_bvalid(bvalid), .axi_bready(bready), .axi_bid(bid),
        .axi_bresp(bresp),
        .axi_arvalid(arvalid), .axi_arready(arready), .axi_arid(arid), .axi_araddr(araddr),
        .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
        .axi_rvalid(rvalid), .axi_rready(rready), .axi_rid(rid), .axi_rdata(rdata),
        .axi_rresp(rresp), .axi_rlast(rlast),
        .timeout_err(timeout_err), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    // Knobs driven by the stimulus block
    logic            aw_block, w_toggle, rlast_bad, mem_clr;
    logic [1:0]      bresp_inj;
    logic [ID_W-1:0] bid_xor;

    // Slave state and logs
    logic [255:0]    mem [0:511];
    logic            have_aw, b_pend, r_pend;
    int              wbeat, rbeat;
    logic [63:0]     s_awaddr, s_araddr;
    logic [ID_W-1:0] s_awid, s_arid;
    logic [7:0]      l_awlen;
    logic [2:0]      l_awsize;
    logic [1:0]      l_awburst;
    logic [31:0]     wstrb_log [0:1];
    logic            wlast_log [0:1];
    int              aw_cnt = 0, ar_cnt = 0, w_beats = 0, awv_cycles = 0, proto_viol = 0;

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] d,
                                           input logic [31:0] s);
        logic [255:0] r;
        r = old;
        for (int b = 0; b < 32; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; arready <= 1'b0; rvalid <= 1'b0;
            have_aw <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0; wbeat <= 0; rbeat <= 0;
            bid <= '0; bresp <= '0; rid <= '0; rresp <= '0; rlast <= 1'b0; rdata <= '0;
        end else begin
            if (awvalid && awready) begin
                awready <= 1'b0; have_aw <= 1'b1; wbeat <= 0; aw_cnt <= aw_cnt + 1;
                s_awaddr <= awaddr; s_awid <= awid;
                l_awlen <= awlen; l_awsize <= awsize; l_awburst <= awburst;
            end else begin
                awready <= awvalid && !aw_block && !have_aw;
            end
            wready <= have_aw ? (w_toggle ? !wready : 1'b1) : 1'b0;
            if (wvalid && wready) begin
                mem[s_awaddr[13:5] + 9'(wbeat)] <= merge(mem[s_awaddr[13:5] + 9'(wbeat)],
                                                         wdata, wstrb);
                if (wbeat < 2) begin
                    wstrb_log[wbeat] <= wstrb;
                    wlast_log[wbeat] <= wlast;
                end
                wbeat <= wbeat + 1; w_beats <= w_beats + 1;
                if (wlast) begin have_aw <= 1'b0; b_pend <= 1'b1; end
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end else if (b_pend && !bvalid) begin
                bvalid <= 1'b1; b_pend <= 1'b0; bid <= s_awid ^ bid_xor; bresp <= bresp_inj;
            end
            if (arvalid && arready) begin
                arready <= 1'b0; r_pend <= 1'b1; s_araddr <= araddr; s_arid <= arid;
                ar_cnt <= ar_cnt + 1;
            end else begin
                arready <= arvalid && !r_pend && !rvalid;
            end
            if (rvalid && rready) begin
                if (rbeat == 1) begin
                    rvalid <= 1'b0;
                end else begin
                    rbeat <= 1; rdata <= mem[s_araddr[13:5] + 9'd1]; rlast <= 1'b1;
                end
            end else if (r_pend) begin
                r_pend <= 1'b0; rvalid <= 1'b1; rbeat <= 0; rdata <= mem[s_araddr[13:5]];
                rlast <= rlast_bad; rid <= s_arid; rresp <= 2'b00;
            end
        end
    end

    // Protocol monitor: stalled AW/W payloads must stay put
    logic            aw_stall_p, w_stall_p;
    logic [63:0]     awaddr_p;
    logic [255:0]    wdata_p;
    logic [31:0]     wstrb_p;
    logic            wlast_p;
    always @(posedge clk) begin
        if (rst) begin
            aw_stall_p <= 1'b0; w_stall_p <= 1'b0;
        end else begin
            if (awvalid) awv_cycles <= awv_cycles + 1;
            if (aw_stall_p && (!awvalid || awaddr != awaddr_p)) proto_viol <= proto_viol + 1;
            if (w_stall_p && (!wvalid || wdata != wdata_p || wstrb != wstrb_p ||
                              wlast != wlast_p)) proto_viol <= proto_viol + 1;
            aw_stall_p <= awvalid && !awready; awaddr_p <= awaddr;
            w_stall_p  <= wvalid && !wready;
            wdata_p <= wdata; wstrb_p <= wstrb; wlast_p <= wlast;
        end
    end

    typedef struct {
        logic         wr;
        logic [511:0] rdata;
        logic         err;
    } rsp_t;
    rsp_t sb[$];

    int checks = 0, failures = 0;
    int exp_id = 0, exp_wr = 0, exp_rd = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [511:0] data,
                          input logic [63:0] mask, input logic [511:0] exp_rdata,
                          input logic exp_err, input bit bus, input int hold, output int lat);
        rsp_t e, got;
        int   n, aw0, ar0;
        e.wr = wr; e.rdata = exp_rdata; e.err = exp_err;
        sb.push_back(e);
        aw0 = aw_cnt; ar0 = ar_cnt; lat = -1;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; req_wmask = mask;
        n = 0;
        while (!req_ready && n < 100) begin step(); n++; end
        if (!req_ready) begin
            chk("req_accept", 0, 1);
            req_valid = 1'b0; void'(sb.pop_front()); return;
        end
        step();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 3000) begin step(); n++; end
        if (!rsp_valid) begin
            chk("rsp_wait", 0, 1);
            void'(sb.pop_front()); return;
        end
        lat = n;
        repeat (hold) step();
        if (hold > 0) chk("rsp_held", rsp_valid, 1);
        got = sb.pop_front();
        chk("rsp_wr", rsp_wr, got.wr);
        chk("rsp_rdata", rsp_rdata, got.rdata);
        chk("rsp_err", rsp_err, got.err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
        if (bus && wr) begin
            chk("aw_once", aw_cnt - aw0, 1);
            chk("awid", s_awid, exp_id);
        end else if (bus) begin
            chk("ar_once", ar_cnt - ar0, 1);
            chk("arid", s_arid, exp_id);
        end
        if (bus) exp_id = (exp_id + 1) % 64;
    endtask

    logic [511:0] full_line, half_line, half_data;
    int           lat, w0, aw0, awv0;

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        rsp_ready = 1'b0;
        aw_block = 1'b0; w_toggle = 1'b0; rlast_bad = 1'b0; bresp_inj = 2'b00; bid_xor = '0;
        full_line = {{32{8'h55}}, {32{8'hAA}}};
        half_data = {64{8'h3C}};
        half_line = {full_line[511:128], half_data[127:0]};
        repeat (3) step();
        rst = 1'b0; mem_clr = 1'b0;
        step();

        chk("rst_req_ready", req_ready, 1);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_cnts", {wr_cnt, rd_cnt}, 0);

        // Full write, then read back
        w0 = w_beats;
        do_req(1'b1, 64'h1000, full_line, '1, '0, 1'b0, 1'b1, 0, lat);
        exp_wr++;
        chk("full_awaddr", s_awaddr, 64'h1000);
        chk("full_awfields", {l_awlen, l_awsize, l_awburst}, {8'd1, 3'd5, 2'b01});
        chk("full_wstrb0", wstrb_log[0], 32'hFFFF_FFFF);
        chk("full_wstrb1", wstrb_log[1], 32'hFFFF_FFFF);
        chk("full_wlast", {wlast_log[1], wlast_log[0]}, 2'b10);
        chk("full_beats", w_beats - w0, 2);
        chk("full_wr_cnt", wr_cnt, exp_wr);
        do_req(1'b0, 64'h1000, '0, '0, full_line, 1'b0, 1'b1, 0, lat);
        exp_rd++;
        chk("rd_araddr", s_araddr, 64'h1000);
        chk("rd_cnt1", rd_cnt, exp_rd);

        // Half-line write to an unaligned address
        do_req(1'b1, 64'h103F, half_data, 64'hFFFF, '0, 1'b0, 1'b1, 0, lat);
        exp_wr++;
        chk("half_awaddr", s_awaddr, 64'h1000);
        chk("half_wstrb0", wstrb_log[0], 32'h0000_FFFF);
        chk("half_wstrb1", wstrb_log[1], 32'h0);
        do_req(1'b0, 64'h1000, '0, '0, half_line, 1'b0, 1'b1, 0, lat);
        exp_rd++;

        // Zero-mask write completes without bus traffic
        aw0 = aw_cnt; awv0 = awv_cycles;
        do_req(1'b1, 64'h1400, full_line, '0, '0, 1'b0, 1'b0, 0, lat);
        chk("zero_lat", lat, 2);
        chk("zero_no_aw", awv_cycles - awv0, 0);
        chk("zero_aw_cnt", aw_cnt - aw0, 0);
        chk("zero_wr_cnt", wr_cnt, exp_wr);

        // Backpressure on every channel
        w0 = w_beats; aw_block = 1'b1; w_toggle = 1'b1;
        fork
            do_req(1'b1, 64'h2000, full_line, '1, '0, 1'b0, 1'b1, 3, lat);
            begin repeat (7) @(posedge clk); #1 aw_block = 1'b0; end
        join
        exp_wr++; w_toggle = 1'b0;
        chk("bp_beats", w_beats - w0, 2);
        chk("bp_proto", proto_viol, 0);

        // Error responses
        bresp_inj = 2'd2;
        do_req(1'b1, 64'h2040, full_line, '1, '0, 1'b1, 1'b1, 0, lat);
        exp_wr++; bresp_inj = 2'd0;
        bid_xor = 6'h01;
        do_req(1'b1, 64'h2080, full_line, '1, '0, 1'b1, 1'b1, 0, lat);
        exp_wr++; bid_xor = '0;
        rlast_bad = 1'b1;
        do_req(1'b0, 64'h1000, '0, '0, half_line, 1'b1, 1'b1, 0, lat);
        exp_rd++; rlast_bad = 1'b0;
        chk("err_wr_cnt", wr_cnt, exp_wr);

        // ID wrap: 64 bus transactions so far after this loop, 65th uses id 0
        for (int i = 0; i < 56; i++) begin
            do_req(1'b0, 64'h3000 + 64'(i * 64), '0, '0, '0, 1'b0, 1'b1, 0, lat);
            exp_rd++;
        end
        do_req(1'b0, 64'h1000, '0, '0, half_line, 1'b0, 1'b1, 0, lat);
        exp_rd++;
        chk("id_wrap", s_arid, 0);
        chk("wrap_rd_cnt", rd_cnt, exp_rd);
        chk("wrap_wr_cnt", wr_cnt, exp_wr);

        // Timeout while AW is stalled, then reset mid-transaction
        aw_block = 1'b1;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 64'h1000; req_wdata = full_line;
        req_wmask = '1;
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (i == 1000) chk("tmo_early", timeout_err, 0);
        end
        chk("tmo_set", timeout_err, 1);
        chk("tmo_aw_held", awvalid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; aw_block = 1'b0;
        chk("rst_mid_awvalid", awvalid, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_timeout", timeout_err, 0);
        chk("rst_mid_cnts", {wr_cnt, rd_cnt}, 0);
        exp_id = 0; exp_wr = 0; exp_rd = 0;
        step();
        do_req(1'b0, 64'h1000, '0, '0, half_line, 1'b0, 1'b1, 0, lat);
        exp_rd++;
        chk("post_rst_rd_cnt", rd_cnt, exp_rd);
        chk("final_proto", proto_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
